// File: rtl/strip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port pixel RAM between strip readers and the host.
// Define STRIP_ARB_HOST_PRIORITY_EN to give host writes fixed priority over all reads.
module strip_mem_arbiter #(
  parameter int NUM_PORTS     = 4,
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_PORTS-1:0]               rd_req,
  input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] rd_addr,
  output logic [NUM_PORTS-1:0]               rd_ack,
  output logic [DATA_WIDTH-1:0]              rd_data,
  output logic [NUM_PORTS-1:0]               rd_valid,
  input  logic                               wr_req,
  input  logic [ADDRESS_WIDTH-1:0]           wr_addr,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  output logic                               wr_ack,
  output logic [ADDRESS_WIDTH-1:0]           mem_addr,
  output logic                               mem_en,
  output logic                               mem_we,
  output logic [DATA_WIDTH-1:0]              mem_wdata,
  input  logic [DATA_WIDTH-1:0]              mem_rdata
);

`ifdef STRIP_ARB_HOST_PRIORITY_EN
  localparam int SLOTS = NUM_PORTS;
`else
  localparam int SLOTS = NUM_PORTS + 1;
`endif
  localparam int PW   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int PADW = 1 << PW;

  logic [PW-1:0]            r_ptr;
  logic [PW-1:0]            w_ptr_nxt;
  logic [PW-1:0]            w_sel;
  logic [PADW-1:0]          w_req_pad;
  logic                     w_found;
  logic                     w_any;
  logic                     w_wr_gnt;
  logic [NUM_PORTS-1:0]     w_rd_gnt;
  logic [ADDRESS_WIDTH-1:0] w_gnt_addr;

  logic                     r_mem_en;
  logic                     r_mem_we;
  logic [ADDRESS_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0]    r_mem_wdata;
  logic [NUM_PORTS-1:0]     r_pend;
  logic [NUM_PORTS-1:0]     r_rd_valid;
  logic [DATA_WIDTH-1:0]    r_rd_data;

  // Host occupies the slot just past the last reader in the rotation.
  always_comb begin
    w_req_pad = '0;
    w_req_pad[NUM_PORTS-1:0] = rd_req;
`ifndef STRIP_ARB_HOST_PRIORITY_EN
    w_req_pad[NUM_PORTS] = wr_req;
`endif
  end

  always_comb begin
    logic [PW:0] v_idx;
    v_idx   = '0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < SLOTS; i++) begin
      v_idx = {1'b0, r_ptr} + (PW+1)'(i);
      if (v_idx >= (PW+1)'(SLOTS))
        v_idx = v_idx - (PW+1)'(SLOTS);
      if (!w_found && w_req_pad[v_idx[PW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = v_idx[PW-1:0];
      end
    end
  end

  always_comb begin
    w_rd_gnt   = '0;
    w_gnt_addr = '0;
    w_ptr_nxt  = r_ptr;
`ifdef STRIP_ARB_HOST_PRIORITY_EN
    w_wr_gnt = !rst && wr_req;
    w_any    = !rst && w_found && !w_wr_gnt;
`else
    w_any    = !rst && w_found;
    w_wr_gnt = w_any && (w_sel == PW'(NUM_PORTS));
`endif
    if (w_any) begin
      w_ptr_nxt = (w_sel == PW'(SLOTS - 1)) ? '0 : w_sel + 1'b1;
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (w_sel == PW'(k)) begin
          w_rd_gnt[k] = 1'b1;
          w_gnt_addr  = rd_addr[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        end
      end
    end
    if (w_wr_gnt)
      w_gnt_addr = wr_addr;
  end

  // Address/data are captured only on the grant edge; RAM controls idle otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_pend      <= '0;
      r_rd_valid  <= '0;
      r_rd_data   <= '0;
    end else begin
      r_ptr      <= w_ptr_nxt;
      r_mem_en   <= w_wr_gnt | (|w_rd_gnt);
      r_mem_we   <= w_wr_gnt;
      r_pend     <= w_rd_gnt;
      r_rd_valid <= r_pend;
      if (w_wr_gnt | (|w_rd_gnt))
        r_mem_addr <= w_gnt_addr;
      if (w_wr_gnt)
        r_mem_wdata <= wr_data;
      if (|r_pend)
        r_rd_data <= mem_rdata;
    end
  end

  assign rd_ack    = w_rd_gnt;
  assign wr_ack    = w_wr_gnt;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;

endmodule

// File: tb/tb_strip_mem_arbiter.sv
// Directed bench for strip_mem_arbiter with assertion checks at each step.
// Host-priority expectations follow STRIP_ARB_HOST_PRIORITY_EN.
module tb_strip_mem_arbiter;

  localparam int NP = 4;
  localparam int AW = 13;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] rd_req;
  logic [NP*AW-1:0] rd_addr;
  logic [NP-1:0] rd_ack;
  logic [DW-1:0] rd_data;
  logic [NP-1:0] rd_valid;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic [AW-1:0] mem_addr;
  logic          mem_en;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  strip_mem_arbiter #(
    .NUM_PORTS(NP), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    rd_req = '0;
    wr_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    rd_req    = '0;
    rd_addr   = '0;
    wr_req    = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    mem_rdata = '0;

    // reset state
    tick();
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    rd_req = 4'b1111;
    wr_req = 1'b1;
    #1;
    chk("rst_rd_ack", 32'(rd_ack), 32'h0);
    chk("rst_wr_ack", 32'(wr_ack), 32'h0);
    tick();
    chk("rst_no_access", 32'(mem_en), 32'h0);
    rd_req = '0;
    wr_req = 1'b0;
    rst    = 1'b0;

    // single read on port 2
    set_addr(2, 13'h005);
    mem_rdata = 8'hA5;
    rd_req    = 4'b0100;
    #1;
    chk("single_ack", 32'(rd_ack), 32'h4);
    chk("single_wr_ack", 32'(wr_ack), 32'h0);
    tick();
    rd_req = '0;
    set_addr(2, 13'h1FF);
    #1;
    chk("single_mem_en", 32'(mem_en), 32'h1);
    chk("single_mem_we", 32'(mem_we), 32'h0);
    chk("single_mem_addr", 32'(mem_addr), 32'h005);
    chk("single_no_early_valid", 32'(rd_valid), 32'h0);
    tick();
    chk("single_valid", 32'(rd_valid), 32'h4);
    chk("single_data", 32'(rd_data), 32'hA5);
    chk("single_idle_en", 32'(mem_en), 32'h0);
    chk("single_addr_hold", 32'(mem_addr), 32'h005);
    tick();
    chk("single_valid_clr", 32'(rd_valid), 32'h0);
    chk("single_data_hold", 32'(rd_data), 32'hA5);

    // continuous requests from all ports
    do_reset();
    for (int k = 0; k < NP; k++) set_addr(k, 13'(13'h100 + k));
    mem_rdata = 8'h77;
    rd_req    = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rr_ack", 32'(rd_ack), 32'(1 << (i % 4)));
      if (i >= 1) begin
        chk("rr_mem_en", 32'(mem_en), 32'h1);
        chk("rr_mem_addr", 32'(mem_addr), 32'(32'h100 + (i - 1) % 4));
      end
      if (i >= 2)
        chk("rr_valid", 32'(rd_valid), 32'(1 << ((i - 2) % 4)));
      tick();
    end
    rd_req = '0;
    #1;
    chk("rr_tail_ack", 32'(rd_ack), 32'h0);
    chk("rr_tail_addr", 32'(mem_addr), 32'h103);
    chk("rr_tail_valid", 32'(rd_valid), 32'h4);
    tick();
    chk("rr_last_valid", 32'(rd_valid), 32'h8);
    chk("rr_last_data", 32'(rd_data), 32'h77);
    chk("rr_idle_en", 32'(mem_en), 32'h0);

    // host write competing with reads
    do_reset();
    wr_req  = 1'b1;
    wr_addr = 13'h010;
    wr_data = 8'h3C;
    rd_req  = 4'b0011;
`ifdef STRIP_ARB_HOST_PRIORITY_EN
    #1;
    chk("hp_wr_ack", 32'(wr_ack), 32'h1);
    chk("hp_rd_ack", 32'(rd_ack), 32'h0);
    tick();
    wr_req  = 1'b0;
    wr_data = 8'hFF;
    #1;
    chk("hp_mem_we", 32'(mem_we), 32'h1);
    chk("hp_mem_addr", 32'(mem_addr), 32'h010);
    chk("hp_mem_wdata", 32'(mem_wdata), 32'h3C);
    chk("hp_ptr_held", 32'(rd_ack), 32'h1);
    tick();
    rd_req = '0;
    chk("hp_rd_we", 32'(mem_we), 32'h0);
    chk("hp_rd_en", 32'(mem_en), 32'h1);
    chk("hp_wdata_hold", 32'(mem_wdata), 32'h3C);
`else
    #1;
    chk("rr_host_ack0", 32'(rd_ack), 32'h1);
    chk("rr_host_wr0", 32'(wr_ack), 32'h0);
    tick();
    chk("rr_host_ack1", 32'(rd_ack), 32'h2);
    chk("rr_host_wr1", 32'(wr_ack), 32'h0);
    chk("rr_host_we1", 32'(mem_we), 32'h0);
    tick();
    chk("rr_host_wr2", 32'(wr_ack), 32'h1);
    chk("rr_host_rd2", 32'(rd_ack), 32'h0);
    tick();
    wr_req  = 1'b0;
    wr_data = 8'hFF;
    rd_req  = '0;
    #1;
    chk("rr_host_we", 32'(mem_we), 32'h1);
    chk("rr_host_addr", 32'(mem_addr), 32'h010);
    chk("rr_host_wdata", 32'(mem_wdata), 32'h3C);
    chk("rr_host_valid1", 32'(rd_valid), 32'h2);
    tick();
    chk("rr_host_idle_en", 32'(mem_en), 32'h0);
    chk("rr_host_idle_we", 32'(mem_we), 32'h0);
    chk("rr_host_wdata_hold", 32'(mem_wdata), 32'h3C);
    chk("rr_host_no_valid", 32'(rd_valid), 32'h0);
`endif

    // reset in the cycle after a read grant
    do_reset();
    set_addr(0, 13'h020);
    set_addr(3, 13'h033);
    mem_rdata = 8'h5A;
    rd_req    = 4'b0001;
    #1;
    chk("mr_ack", 32'(rd_ack), 32'h1);
    tick();
    rst    = 1'b1;
    rd_req = '0;
    #1;
    chk("mr_ack_in_rst", 32'(rd_ack), 32'h0);
    chk("mr_en_before", 32'(mem_en), 32'h1);
    tick();
    rst    = 1'b0;
    rd_req = 4'b1000;
    #1;
    chk("mr_no_valid", 32'(rd_valid), 32'h0);
    chk("mr_en_cleared", 32'(mem_en), 32'h0);
    chk("mr_data_cleared", 32'(rd_data), 32'h0);
    chk("mr_p3_ack", 32'(rd_ack), 32'h8);
    tick();
    rd_req = '0;
    #1;
    chk("mr_still_no_valid", 32'(rd_valid), 32'h0);
    chk("mr_p3_addr", 32'(mem_addr), 32'h033);
    tick();
    chk("mr_p3_valid", 32'(rd_valid), 32'h8);
    chk("mr_p3_data", 32'(rd_data), 32'h5A);

    // port 1 withdraws while port 0 is granted
    do_reset();
    set_addr(1, 13'h011);
    rd_req = 4'b0011;
    #1;
    chk("wd_ack0", 32'(rd_ack), 32'h1);
    rd_req = 4'b0001;
    #1;
    chk("wd_ack0_kept", 32'(rd_ack), 32'h1);
    tick();
    rd_req = '0;
    #1;
    chk("wd_no_ack1", 32'(rd_ack), 32'h0);
    chk("wd_addr0", 32'(mem_addr), 32'h020);
    tick();
    chk("wd_no_en", 32'(mem_en), 32'h0);
    chk("wd_valid0", 32'(rd_valid), 32'h1);
    chk("wd_addr_hold", 32'(mem_addr), 32'h020);
    tick();
    chk("wd_quiet_valid", 32'(rd_valid), 32'h0);
    chk("wd_quiet_en", 32'(mem_en), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
